// File: rtl/spi_boot_loader.sv
// SPI boot loader: receives an image from the ARM over SPI and writes it to
// external SRAM through a request/acknowledge write port.
//
// The image starts with a 6-byte header: a 24-bit start address, then a 24-bit
// end address, each sent LSB byte first. Every following byte is written to
// start, start+1, ... up to and including end.
//
// Ports
//   clk, reset_b          system clock, asynchronous active-low reset
//   arm_ss/sclk/mosi      SPI slave inputs (mode 3, MSB first), asynchronous
//   wr_req, wr_ack        RAM write handshake; wr_req held until wr_ack
//   ram_addr, ram_data    write address (low ADDR_WIDTH bits) and data
//   booting               high while a load is in progress (CPU held in reset)
//   done, error           sticky load status, cleared by the next ss fall
module spi_boot_loader #(
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  arm_ss,
    input  logic                  arm_sclk,
    input  logic                  arm_mosi,
    output logic                  wr_req,
    input  logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_data,
    output logic                  booting,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic        ss_prev, sclk_prev;
    logic        live, armed;
    logic [6:0]  shreg;
    logic [2:0]  bit_cnt;
    logic [2:0]  hdr_cnt;
    logic [47:0] hdr;
    logic [23:0] cur;

    logic        ss_s, sclk_s, mosi_s;
    logic        ss_fall, ss_rise, sclk_rise, byte_done, ack_hit;
    logic [7:0]  rx_byte;
    logic [47:0] hdr_full;
    logic [23:0] cur_nxt;

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_fall   = armed & ss_prev & ~ss_s;
    assign ss_rise   = ~ss_prev & ss_s;
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign byte_done = sclk_rise & ~ss_s & (bit_cnt == 3'd7);
    assign rx_byte   = {shreg, mosi_s};
    assign ack_hit   = wr_req & wr_ack;
    assign cur_nxt   = ack_hit ? cur + 24'd1 : cur;
    // Header bytes shift in from the top, so after byte 5 the low 24 bits are
    // start and the high 24 bits are end.
    assign hdr_full  = {rx_byte, hdr[47:8]};

    // Synchronisers reset to the idle levels. A fall is only accepted once ss
    // has been seen high through the whole chain after reset, so ss held low
    // across reset release is not mistaken for a new load.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ss_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '0;
            ss_prev   <= 1'b1;
            sclk_prev <= 1'b1;
            live      <= 1'b0;
            armed     <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], arm_ss};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], arm_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], arm_mosi};
            ss_prev   <= ss_s;
            sclk_prev <= sclk_s;
            live      <= 1'b1;
            if (live && (&ss_sync)) armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ss_fall) begin
            state_nxt = HDR;
        end else if (ss_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                HDR: begin
                    if (byte_done && hdr_cnt == 3'd5)
                        state_nxt = (hdr_full[47:24] >= hdr_full[23:0]) ? DATA : ERR;
                end
                DATA: begin
                    // The final acceptance wins over a byte landing in the same cycle.
                    if (ack_hit && cur == hdr[47:24])
                        state_nxt = DONE;
                    else if (byte_done && wr_req && !wr_ack)
                        state_nxt = ERR;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            hdr_cnt  <= '0;
            hdr      <= '0;
            cur      <= '0;
            wr_req   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            booting  <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (ss_fall || ss_rise) begin
                bit_cnt <= '0;
            end else if (sclk_rise && !ss_s) begin
                shreg   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end

            // A write pending when ss rises still completes its handshake.
            cur <= cur_nxt;
            if (ack_hit) wr_req <= 1'b0;

            if (ss_fall) begin
                hdr_cnt <= '0;
                booting <= 1'b1;
                done    <= 1'b0;
                error   <= 1'b0;
            end else if (ss_rise) begin
                booting <= 1'b0;
                if (state == HDR || state == DATA) error <= 1'b1;
            end else begin
                if (state == HDR && byte_done) begin
                    hdr     <= hdr_full;
                    hdr_cnt <= hdr_cnt + 3'd1;
                    if (hdr_cnt == 3'd5) cur <= hdr_full[23:0];
                end
                // Staying in DATA with a completed byte means no write is pending.
                if (state == DATA && state_nxt == DATA && byte_done) begin
                    ram_data <= rx_byte;
                    ram_addr <= cur_nxt[ADDR_WIDTH-1:0];
                    wr_req   <= 1'b1;
                end
                if (state_nxt == ERR && state != ERR)   error <= 1'b1;
                if (state_nxt == DONE && state != DONE) done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_boot_loader.sv
// Self-checking bench for spi_boot_loader: drives SPI loads with a RAM
// arbiter model, records every accepted write and compares against the
// expected write list derived from the header and the bytes sent.
module tb_spi_boot_loader;

    localparam int unsigned AW   = 18;
    localparam int          HALF = 25;  // 20 MHz SPI against a 100 MHz clock

    logic          clk = 1'b0;
    logic          reset_b;
    logic          arm_ss, arm_sclk, arm_mosi;
    logic          wr_req;
    logic          wr_ack = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic          booting, done, error;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned ack_delay = 0;
    int unsigned ack_wait  = 0;
    int unsigned req_rises = 0;
    logic        req_d     = 1'b0;

    int unsigned obs_q[$];
    int unsigned exp_q[$];
    logic [7:0]  tx_q[$];
    logic        exp_done, exp_err;

    spi_boot_loader #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .arm_ss   (arm_ss),
        .arm_sclk (arm_sclk),
        .arm_mosi (arm_mosi),
        .wr_req   (wr_req),
        .wr_ack   (wr_ack),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .booting  (booting),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // RAM arbiter: single-cycle wr_ack after ack_delay cycles of wr_req,
    // capturing the write it accepts.
    always @(negedge clk) begin
        if (wr_req && !req_d) req_rises++;
        req_d = wr_req;
        if (wr_ack) begin
            wr_ack = 1'b0;
        end else if (wr_req) begin
            if (ack_wait >= ack_delay) begin
                wr_ack   = 1'b1;
                ack_wait = 0;
                obs_q.push_back((32'(ram_addr) << 8) | 32'(ram_data));
            end else begin
                ack_wait++;
            end
        end else begin
            ack_wait = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic spi_bit(input logic b);
        arm_sclk = 1'b0;
        arm_mosi = b;
        #HALF;
        arm_sclk = 1'b1;
        #HALF;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic send_header(input logic [23:0] s, input logic [23:0] e);
        spi_byte(s[7:0]);  spi_byte(s[15:8]);  spi_byte(s[23:16]);
        spi_byte(e[7:0]);  spi_byte(e[15:8]);  spi_byte(e[23:16]);
    endtask

    // Expected outcome of a load: bytes land at start, start+1, ... until end
    // is written; a reversed header writes nothing; running out of bytes
    // before end is reached (ss rises early) is an error.
    task automatic model(input logic [23:0] s, input logic [23:0] e);
        int unsigned span;
        exp_q.delete();
        if (e < s) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end else begin
            span = 32'(e) - 32'(s) + 1;
            for (int unsigned i = 0; i < 32'(tx_q.size()) && i < span; i++)
                exp_q.push_back((((32'(s) + i) % (32'd1 << AW)) << 8) | 32'(tx_q[i]));
            exp_done = (32'(tx_q.size()) >= span);
            exp_err  = !exp_done;
        end
    endtask

    task automatic drain(input string tag);
        int unsigned n;
        n = 0;
        repeat (6) @(negedge clk);
        while (wr_req && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/drain"}, 32'(wr_req), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_load(input string tag, input logic [23:0] s, input logic [23:0] e,
                            input int unsigned extra_bits);
        obs_q.delete();
        req_rises = 0;
        model(s, e);
        arm_ss = 1'b0;
        #100;
        check({tag, "/boot_on"}, 32'(booting), 32'd1);
        check({tag, "/done_clr"}, 32'(done), 32'd0);
        check({tag, "/err_clr"}, 32'(error), 32'd0);
        send_header(s, e);
        foreach (tx_q[i]) spi_byte(tx_q[i]);
        for (int unsigned i = 0; i < extra_bits; i++) spi_bit(1'($urandom_range(0, 1)));
        #200;
        arm_ss = 1'b1;
        drain(tag);
        check({tag, "/n_writes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s/wr%0d", tag, i), obs_q[i], exp_q[i]);
        check({tag, "/done"}, 32'(done), 32'(exp_done));
        check({tag, "/error"}, 32'(error), 32'(exp_err));
        check({tag, "/boot_off"}, 32'(booting), 32'd0);
    endtask

    initial begin
        logic [7:0]  b0;
        int unsigned len, sent;
        logic [23:0] s, e;

        arm_ss   = 1'b1;
        arm_sclk = 1'b1;
        arm_mosi = 1'b0;
        reset_b  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst/wr_req", 32'(wr_req), 32'd0);
        check("rst/booting", 32'(booting), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/error", 32'(error), 32'd0);
        check("rst/ram_addr", 32'(ram_addr), 32'd0);
        check("rst/ram_data", 32'(ram_data), 32'd0);
        reset_b = 1'b1;
        repeat (5) @(negedge clk);

        // Contiguous block (shortened form of the 0x0C000.. boot image)
        tx_q.delete();
        repeat (256) tx_q.push_back(8'($urandom));
        run_load("block", 24'h00C000, 24'h00C0FF, 0);

        // start == end: exactly one write, trailing byte ignored
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h5A);
        run_load("single", 24'h001000, 24'h001000, 0);

        // end < start: no writes, data ignored
        tx_q.delete();
        repeat (3) tx_q.push_back(8'($urandom));
        run_load("badhdr", 24'h002000, 24'h001FFF, 0);

        // ss rises 3 bits into the 2nd data byte, then a clean reload
        tx_q.delete();
        tx_q.push_back(8'h11);
        run_load("early", 24'h000100, 24'h0001FF, 3);
        tx_q.delete();
        repeat (4) tx_q.push_back(8'($urandom));
        run_load("reload", 24'h000200, 24'h000203, 0);

        // address wrap across 2^ADDR_WIDTH
        tx_q.delete();
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'hC3);
        run_load("wrap", 24'h03FFFF, 24'h040000, 0);

        // randomized loads, including short/long byte counts and a bad header
        for (int t = 0; t < 6; t++) begin
            len  = $urandom_range(1, 20);
            s    = 24'($urandom_range(1, 32'hFFFF00));
            e    = 24'(32'(s) + len - 1);
            if (t == 3) e = s - 24'd1;
            sent = $urandom_range(0, len + 2);
            tx_q.delete();
            repeat (sent) tx_q.push_back(8'($urandom));
            ack_delay = $urandom_range(0, 5);
            run_load($sformatf("rnd%0d", t), s, e, $urandom_range(0, 7));
        end
        ack_delay = 0;

        // overrun: ack withheld beyond a byte time
        obs_q.delete();
        req_rises = 0;
        ack_delay = 100;
        b0 = 8'($urandom);
        arm_ss = 1'b0;
        #100;
        send_header(24'h005000, 24'h0050FF);
        spi_byte(b0);
        spi_byte(8'($urandom));
        #100;
        check("ovr/err_set", 32'(error), 32'd1);
        check("ovr/pending", 32'(wr_req), 32'd1);
        spi_byte(8'($urandom));
        #100;
        arm_ss = 1'b1;
        drain("ovr");
        check("ovr/req_rises", req_rises, 32'd1);
        check("ovr/n_writes", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) check("ovr/wr0", obs_q[0], (32'h5000 << 8) | 32'(b0));
        check("ovr/done", 32'(done), 32'd0);
        check("ovr/error", 32'(error), 32'd1);
        check("ovr/boot_off", 32'(booting), 32'd0);

        // reset mid-load with a write pending, ss held low across release
        obs_q.delete();
        ack_delay = 100;
        arm_ss = 1'b0;
        #100;
        send_header(24'h006000, 24'h0060FF);
        spi_byte(8'h77);
        #100;
        check("rst2/pending", 32'(wr_req), 32'd1);
        reset_b = 1'b0;
        #1;
        check("rst2/wr_req", 32'(wr_req), 32'd0);
        check("rst2/booting", 32'(booting), 32'd0);
        repeat (3) @(negedge clk);
        reset_b   = 1'b1;
        req_rises = 0;
        ack_delay = 0;
        spi_byte(8'h12);
        spi_byte(8'h34);
        #100;
        check("rst2/idle_boot", 32'(booting), 32'd0);
        arm_ss = 1'b1;
        repeat (10) @(negedge clk);
        check("rst2/req_rises", req_rises, 32'd0);
        check("rst2/n_writes", 32'(obs_q.size()), 32'd0);
        tx_q.delete();
        repeat (3) tx_q.push_back(8'($urandom));
        run_load("postrst", 24'h000010, 24'h000012, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
